tetris_key_repeat: RTL

//  Parametrised successor to the single-key press decoder. Watches the scan-code

---
 rtl/tetris_key_repeat.sv | 115 +++++++++++
 1 files changed

// File: rtl/tetris_key_repeat.sv
// Per-key press/auto-repeat pulse generator fed by keyboard_press_driver.
// Each watched scan code runs an independent IDLE/DELAY/REPEAT machine.
module tetris_key_repeat #(
    parameter int                     NUM_KEYS     = 4,
    parameter logic [8*NUM_KEYS-1:0]  KEY_CODES    = {8'h75, 8'h74, 8'h72, 8'h6b},
    parameter logic [NUM_KEYS-1:0]    REPEAT_EN    = 4'b0111,
    parameter int                     REPEAT_DELAY = 25_000_000,
    parameter int                     REPEAT_RATE  = 5_000_000,
    parameter int                     CNT_W        =
        $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic                makeBreak,
    input  logic [7:0]          outCode,
    input  logic                clear,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    state_e               state_q [NUM_KEYS];
    state_e               state_d [NUM_KEYS];
    logic [CNT_W-1:0]     cnt_q   [NUM_KEYS];
    logic [CNT_W-1:0]     cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0]  pressed_q, pressed_d;
    logic [NUM_KEYS-1:0]  held_q, held_d;
    logic [NUM_KEYS-1:0]  mk, brk;

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            mk[i]        = valid && (outCode == KEY_CODES[8*i +: 8]) && makeBreak;
            brk[i]       = valid && (outCode == KEY_CODES[8*i +: 8]) && !makeBreak;
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            pressed_d[i] = 1'b0;
            if (clear) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        if (mk[i]) begin
                            state_d[i]   = DELAY;
                            cnt_d[i]     = '0;
                            pressed_d[i] = 1'b1;
                        end
                    end
                    // Typematic makes from the keyboard are ignored while held.
                    DELAY: begin
                        if (brk[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == DLY_LAST) begin
                            if (REPEAT_EN[i]) begin
                                state_d[i]   = REPEAT;
                                cnt_d[i]     = '0;
                                pressed_d[i] = 1'b1;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (brk[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == RATE_LAST) begin
                            cnt_d[i]     = '0;
                            pressed_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            held_d[i] = (state_d[i] != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            pressed_q <= '0;
            held_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pressed_q <= pressed_d;
            held_q    <= held_d;
        end
    end

    assign pressed = pressed_q;
    assign held    = held_q;

endmodule
